// File: rtl/alu_arb_if.sv
// Handshake bundle between two requesters and the shared-ALU arbiter.
// The arbiter connects through the slave modport; requesters (or a bench)
// drive it through the master modport.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 4
`endif

interface alu_arb_if #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int ARGS_WIDTH = `ARGS_WIDTH
);
   // requester 0
   logic                  i_req0_valid;
   logic                  o_req0_ready;
   logic [ARGS_WIDTH-1:0] i_req0_type;
   logic [DATA_WIDTH-1:0] i_req0_rs1_data;
   logic [DATA_WIDTH-1:0] i_req0_rs2_data;
   // requester 1
   logic                  i_req1_valid;
   logic                  o_req1_ready;
   logic [ARGS_WIDTH-1:0] i_req1_type;
   logic [DATA_WIDTH-1:0] i_req1_rs1_data;
   logic [DATA_WIDTH-1:0] i_req1_rs2_data;
   // responses (result and flags shared by both ports)
   logic                  o_rsp0_valid;
   logic                  i_rsp0_ready;
   logic                  o_rsp1_valid;
   logic                  i_rsp1_ready;
   logic [DATA_WIDTH-1:0] o_rsp_res;
   logic                  o_rsp_zero;
   logic                  o_rsp_over;
   logic                  o_rsp_neg;
   logic                  o_busy;

   modport slave (
      input  i_req0_valid, i_req0_type, i_req0_rs1_data, i_req0_rs2_data,
      input  i_req1_valid, i_req1_type, i_req1_rs1_data, i_req1_rs2_data,
      input  i_rsp0_ready, i_rsp1_ready,
      output o_req0_ready, o_req1_ready,
      output o_rsp0_valid, o_rsp1_valid,
      output o_rsp_res, o_rsp_zero, o_rsp_over, o_rsp_neg, o_busy
   );

   modport master (
      output i_req0_valid, i_req0_type, i_req0_rs1_data, i_req0_rs2_data,
      output i_req1_valid, i_req1_type, i_req1_rs1_data, i_req1_rs2_data,
      output i_rsp0_ready, i_rsp1_ready,
      input  o_req0_ready, o_req1_ready,
      input  o_rsp0_valid, o_rsp1_valid,
      input  o_rsp_res, o_rsp_zero, o_rsp_over, o_rsp_neg, o_busy
   );
endinterface

// File: rtl/alu_arb.sv
// Two-requester arbiter around a single combinational ALU. A granted
// request is computed in its accept cycle and the result is held in an
// output register until the owning requester takes it; a new request may
// be accepted in the same cycle the held result is consumed.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 4
`endif
`ifndef ALU_TYPE_ADD
`define ALU_TYPE_ADD 4'd0
`define ALU_TYPE_SUB 4'd1
`define ALU_TYPE_AND 4'd2
`define ALU_TYPE_OR  4'd3
`define ALU_TYPE_XOR 4'd4
`define ALU_TYPE_SLL 4'd5
`define ALU_TYPE_SRL 4'd6
`define ALU_TYPE_SRA 4'd7
`define ALU_TYPE_SLT 4'd8
`endif

// Combinational ALU: result plus zero / signed-overflow / negative flags.
// Unknown operation codes yield a zero result (so zero=1, others 0).
module alu #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int ARGS_WIDTH = `ARGS_WIDTH
) (
   input  logic [ARGS_WIDTH-1:0] op_type,
   input  logic [DATA_WIDTH-1:0] rs1,
   input  logic [DATA_WIDTH-1:0] rs2,
   output logic [DATA_WIDTH-1:0] res,
   output logic                  zero,
   output logic                  over,
   output logic                  neg
);
   localparam int SHW = $clog2(DATA_WIDTH);
   localparam int MSB = DATA_WIDTH - 1;

   logic [SHW-1:0]        shamt_s;
   logic [DATA_WIDTH-1:0] sum_s;
   logic [DATA_WIDTH-1:0] diff_s;

   assign shamt_s = rs2[SHW-1:0];
   assign sum_s   = rs1 + rs2;
   assign diff_s  = rs1 - rs2;

   // Operation decode; overflow only meaningful for add/sub.
   always_comb begin
      res  = {DATA_WIDTH{1'b0}};
      over = 1'b0;
      case (op_type)
         `ALU_TYPE_ADD: begin
            res  = sum_s;
            over = (rs1[MSB] == rs2[MSB]) && (sum_s[MSB] != rs1[MSB]);
         end
         `ALU_TYPE_SUB: begin
            res  = diff_s;
            over = (rs1[MSB] != rs2[MSB]) && (diff_s[MSB] != rs1[MSB]);
         end
         `ALU_TYPE_AND: res = rs1 & rs2;
         `ALU_TYPE_OR:  res = rs1 | rs2;
         `ALU_TYPE_XOR: res = rs1 ^ rs2;
         `ALU_TYPE_SLL: res = rs1 << shamt_s;
         `ALU_TYPE_SRL: res = rs1 >> shamt_s;
         `ALU_TYPE_SRA: res = $signed(rs1) >>> shamt_s;
         `ALU_TYPE_SLT: res = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
         default: begin
            res  = {DATA_WIDTH{1'b0}};
            over = 1'b0;
         end
      endcase
   end

   assign zero = (res == {DATA_WIDTH{1'b0}});
   assign neg  = res[MSB];
endmodule

module alu_arb #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int ARGS_WIDTH = `ARGS_WIDTH
) (
   input  logic     i_clk,
   input  logic     i_rst,
   alu_arb_if.slave bus
);
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic                  pri_r;      // favoured requester on contention
   logic                  own_r;      // owner of the held result
   logic [DATA_WIDTH-1:0] res_r;
   logic                  zero_r;
   logic                  over_r;
   logic                  neg_r;

   logic                  grant_s;
   logic                  own_rsp_ready_s;
   logic                  can_take_s;
   logic                  ready0_s;
   logic                  ready1_s;
   logic                  accept_s;
   logic                  handshake_s;

   logic [ARGS_WIDTH-1:0] alu_type_s;
   logic [DATA_WIDTH-1:0] alu_rs1_s;
   logic [DATA_WIDTH-1:0] alu_rs2_s;
   logic [DATA_WIDTH-1:0] alu_res_s;
   logic                  alu_zero_s;
   logic                  alu_over_s;
   logic                  alu_neg_s;

   // Grant: a lone requester always wins, contention resolved by pri_r.
   always_comb begin
      grant_s = 1'b0;
      if (bus.i_req0_valid && bus.i_req1_valid) begin
         grant_s = pri_r;
      end else if (bus.i_req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   // Acceptance: only when the output register is free or being drained
   // this cycle by its owner; never while reset is asserted.
   always_comb begin
      own_rsp_ready_s = own_r ? bus.i_rsp1_ready : bus.i_rsp0_ready;
      handshake_s     = (state_r == ST_RESP) && own_rsp_ready_s;
      can_take_s      = !i_rst && ((state_r == ST_IDLE) || own_rsp_ready_s);
      ready0_s        = can_take_s && bus.i_req0_valid && !grant_s;
      ready1_s        = can_take_s && bus.i_req1_valid && grant_s;
      accept_s        = ready0_s || ready1_s;
   end

   // Operand mux: the ALU always sees the granted requester.
   always_comb begin
      alu_type_s = bus.i_req0_type;
      alu_rs1_s  = bus.i_req0_rs1_data;
      alu_rs2_s  = bus.i_req0_rs2_data;
      if (grant_s) begin
         alu_type_s = bus.i_req1_type;
         alu_rs1_s  = bus.i_req1_rs1_data;
         alu_rs2_s  = bus.i_req1_rs2_data;
      end else begin
         alu_type_s = bus.i_req0_type;
         alu_rs1_s  = bus.i_req0_rs1_data;
         alu_rs2_s  = bus.i_req0_rs2_data;
      end
   end

   alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .ARGS_WIDTH (ARGS_WIDTH)
   ) u_alu (
      .op_type (alu_type_s),
      .rs1     (alu_rs1_s),
      .rs2     (alu_rs2_s),
      .res     (alu_res_s),
      .zero    (alu_zero_s),
      .over    (alu_over_s),
      .neg     (alu_neg_s)
   );

   // Next state: leave RESP only when the result drains with nothing new.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RESP: begin
            if (handshake_s && !accept_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register; reset wins over any same-cycle handshake.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Result/ownership registers: loaded only on accept, otherwise held.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pri_r  <= 1'b0;
         own_r  <= 1'b0;
         res_r  <= {DATA_WIDTH{1'b0}};
         zero_r <= 1'b0;
         over_r <= 1'b0;
         neg_r  <= 1'b0;
      end else if (accept_s) begin
         pri_r  <= !grant_s;
         own_r  <= grant_s;
         res_r  <= alu_res_s;
         zero_r <= alu_zero_s;
         over_r <= alu_over_s;
         neg_r  <= alu_neg_s;
      end
   end

   assign bus.o_req0_ready = ready0_s;
   assign bus.o_req1_ready = ready1_s;
   assign bus.o_rsp0_valid = (state_r == ST_RESP) && !own_r;
   assign bus.o_rsp1_valid = (state_r == ST_RESP) && own_r;
   assign bus.o_rsp_res    = res_r;
   assign bus.o_rsp_zero   = zero_r;
   assign bus.o_rsp_over   = over_r;
   assign bus.o_rsp_neg    = neg_r;
   assign bus.o_busy       = (state_r == ST_RESP);
endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb with a result scoreboard: every accepted
// request pushes its expected result; every presented response is checked
// against the queue head and popped on the response handshake.
module tb_alu_arb;
   localparam int DW = 32;
   localparam int AW = 4;

   localparam logic [3:0] T_ADD = 4'd0;
   localparam logic [3:0] T_SUB = 4'd1;
   localparam logic [3:0] T_AND = 4'd2;
   localparam logic [3:0] T_OR  = 4'd3;
   localparam logic [3:0] T_XOR = 4'd4;
   localparam logic [3:0] T_SLL = 4'd5;
   localparam logic [3:0] T_SRL = 4'd6;
   localparam logic [3:0] T_SRA = 4'd7;
   localparam logic [3:0] T_SLT = 4'd8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_arb_if #(.DATA_WIDTH(DW), .ARGS_WIDTH(AW)) bus ();

   alu_arb #(.DATA_WIDTH(DW), .ARGS_WIDTH(AW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic          owner;
      logic [DW-1:0] res;
      logic          zero;
      logic          over;
      logic          neg;
   } exp_t;

   exp_t q[$];
   int   cnt_cmp = 0;
   int   cnt_err = 0;
   int   n_acc   = 0;
   logic pri_m   = 1'b0;

   logic [3:0]  op_ty [0:9] = '{T_ADD, T_SUB, T_SUB, T_SLL, T_SRL, T_SRA, T_SLT, T_XOR, 4'hF, T_OR};
   logic [31:0] op_a  [0:9] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd2, 32'd1, 32'h8000_0000,
                                32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h55, 32'h0};
   logic [31:0] op_b  [0:9] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd31, 32'd4,
                                32'd4, 32'd1, 32'h1234_5678, 32'hAA, 32'h0};

   // Reference ALU using 64-bit signed arithmetic for overflow detection.
   function automatic exp_t model(logic owner, logic [3:0] t, logic [31:0] a, logic [31:0] b);
      exp_t   e;
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.owner = owner;
      e.over  = 1'b0;
      e.res   = 32'd0;
      case (t)
         T_ADD: begin s = sa + sb; e.res = a + b;
                      e.over = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         T_SUB: begin s = sa - sb; e.res = a - b;
                      e.over = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         T_AND: e.res = a & b;
         T_OR:  e.res = a | b;
         T_XOR: e.res = a ^ b;
         T_SLL: e.res = a << b[4:0];
         T_SRL: e.res = a >> b[4:0];
         T_SRA: e.res = 32'(sa >>> b[4:0]);
         T_SLT: e.res = (sa < sb) ? 32'd1 : 32'd0;
         default: e.res = 32'd0;
      endcase
      e.zero = (e.res == 32'd0);
      e.neg  = e.res[31];
      return e;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      cnt_cmp++;
      assert (obs === exp) else begin
         cnt_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Per-cycle scoreboard step, executed at the falling edge.
   task automatic monitor();
      exp_t       f;
      logic       has, can, g;
      logic [1:0] exp_v, exp_rdy;
      if (rst) begin
         chk("ready_in_reset", {bus.o_req1_ready, bus.o_req0_ready}, 2'b00);
         q.delete();
         pri_m = 1'b0;
         return;
      end
      has = (q.size() > 0);
      f   = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
      if (has) f = q[0];
      exp_v = has ? (f.owner ? 2'b10 : 2'b01) : 2'b00;
      chk("rsp_valid", {bus.o_rsp1_valid, bus.o_rsp0_valid}, exp_v);
      chk("busy", bus.o_busy, has);
      if (has) begin
         chk("rsp_res", bus.o_rsp_res, f.res);
         chk("rsp_flags", {bus.o_rsp_zero, bus.o_rsp_over, bus.o_rsp_neg}, {f.zero, f.over, f.neg});
      end
      can = !has || (f.owner ? bus.i_rsp1_ready : bus.i_rsp0_ready);
      g   = (bus.i_req0_valid && bus.i_req1_valid) ? pri_m : bus.i_req1_valid;
      exp_rdy = 2'b00;
      if (can && (bus.i_req0_valid || bus.i_req1_valid)) exp_rdy = g ? 2'b10 : 2'b01;
      chk("req_ready", {bus.o_req1_ready, bus.o_req0_ready}, exp_rdy);
      if (has && can) void'(q.pop_front());
      if (bus.i_req0_valid && bus.o_req0_ready) begin
         q.push_back(model(1'b0, bus.i_req0_type, bus.i_req0_rs1_data, bus.i_req0_rs2_data));
         pri_m = 1'b1;
         n_acc++;
      end else if (bus.i_req1_valid && bus.o_req1_ready) begin
         q.push_back(model(1'b1, bus.i_req1_type, bus.i_req1_rs1_data, bus.i_req1_rs2_data));
         pri_m = 1'b0;
         n_acc++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(logic v, logic [3:0] t, logic [31:0] a, logic [31:0] b);
      bus.i_req0_valid = v; bus.i_req0_type = t;
      bus.i_req0_rs1_data = a; bus.i_req0_rs2_data = b;
   endtask

   task automatic drive1(logic v, logic [3:0] t, logic [31:0] a, logic [31:0] b);
      bus.i_req1_valid = v; bus.i_req1_type = t;
      bus.i_req1_rs1_data = a; bus.i_req1_rs2_data = b;
   endtask

   initial begin
      int n0;
      rst = 1'b1;
      drive0(1'b0, T_ADD, 32'd0, 32'd0);
      drive1(1'b0, T_ADD, 32'd0, 32'd0);
      bus.i_rsp0_ready = 1'b0;
      bus.i_rsp1_ready = 1'b0;
      @(posedge clk); #1;
      drive0(1'b1, T_ADD, 32'd1, 32'd1);   // valid during reset must not be taken
      tick(); tick();
      drive0(1'b0, T_ADD, 32'd0, 32'd0);
      rst = 1'b0;
      chk("reset_res", bus.o_rsp_res, 32'd0);
      chk("reset_flags", {bus.o_rsp_zero, bus.o_rsp_over, bus.o_rsp_neg}, 3'b000);
      chk("reset_busy", bus.o_busy, 1'b0);
      chk("reset_valid", {bus.o_rsp1_valid, bus.o_rsp0_valid}, 2'b00);

      // single op: ADD 5,7
      drive0(1'b1, T_ADD, 32'd5, 32'd7);
      tick();
      drive0(1'b0, T_ADD, 32'd0, 32'd0);
      bus.i_rsp0_ready = 1'b1;
      chk("single_valid", bus.o_rsp0_valid, 1'b1);
      chk("single_res", bus.o_rsp_res, 32'd12);
      chk("single_zero", bus.o_rsp_zero, 1'b0);
      tick();
      chk("single_idle", bus.o_busy, 1'b0);
      tick();

      // contention after reset: req0 first, then alternate
      rst = 1'b1; tick(); rst = 1'b0;
      drive0(1'b1, T_SUB, 32'd3, 32'd3);
      drive1(1'b1, T_XOR, 32'h0F, 32'hF0);
      bus.i_rsp0_ready = 1'b1;
      bus.i_rsp1_ready = 1'b1;
      tick();
      chk("cont_first_owner", {bus.o_rsp1_valid, bus.o_rsp0_valid}, 2'b01);
      chk("cont_first_res", bus.o_rsp_res, 32'd0);
      chk("cont_first_zero", bus.o_rsp_zero, 1'b1);
      tick();
      chk("cont_second_owner", {bus.o_rsp1_valid, bus.o_rsp0_valid}, 2'b10);
      chk("cont_second_res", bus.o_rsp_res, 32'hFF);
      tick(); tick();
      drive0(1'b0, T_ADD, 32'd0, 32'd0);
      drive1(1'b0, T_ADD, 32'd0, 32'd0);
      tick(); tick();

      // back-to-back on req1
      bus.i_rsp0_ready = 1'b0;
      n0 = n_acc;
      for (int i = 0; i < 4; i++) begin
         drive1(1'b1, T_ADD, 32'(i * 100), 32'(i + 1));
         tick();
         chk("b2b_busy", bus.o_busy, 1'b1);
      end
      drive1(1'b0, T_ADD, 32'd0, 32'd0);
      chk("b2b_accepts", 64'(n_acc - n0), 64'd4);
      tick(); tick();

      // backpressure on owner 0; non-owner rsp ready is ignored
      bus.i_rsp1_ready = 1'b1;
      drive0(1'b1, T_OR, 32'hF0F0, 32'h0F0F);
      tick();
      drive0(1'b0, T_ADD, 32'd0, 32'd0);
      drive1(1'b1, T_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_ready1", bus.o_req1_ready, 1'b0);
         chk("bp_res_stable", bus.o_rsp_res, 32'hFFFF);
      end
      bus.i_rsp0_ready = 1'b1;
      #1;
      chk("bp_release_ready1", bus.o_req1_ready, 1'b1);
      tick();
      drive1(1'b0, T_ADD, 32'd0, 32'd0);
      chk("bp_new_owner", {bus.o_rsp1_valid, bus.o_rsp0_valid}, 2'b10);
      tick(); tick();

      // operation table incl. overflow and undefined type
      bus.i_rsp0_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive0(1'b1, op_ty[i], op_a[i], op_b[i]);
         tick();
         if (i == 0) begin
            chk("ovf_over", bus.o_rsp_over, 1'b1);
            chk("ovf_res", bus.o_rsp_res, 32'd0);
            chk("ovf_zero", bus.o_rsp_zero, 1'b1);
         end
      end
      drive0(1'b0, T_ADD, 32'd0, 32'd0);
      tick(); tick();

      // reset in RESP drops the held result and restores priority to req0
      bus.i_rsp0_ready = 1'b0;
      drive0(1'b1, T_ADD, 32'd1, 32'd2);
      tick();
      drive0(1'b0, T_ADD, 32'd0, 32'd0);
      chk("rst_mid_busy_before", bus.o_busy, 1'b1);
      rst = 1'b1;
      bus.i_rsp0_ready = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_valid", {bus.o_rsp1_valid, bus.o_rsp0_valid}, 2'b00);
      chk("rst_mid_busy", bus.o_busy, 1'b0);
      chk("rst_mid_res", bus.o_rsp_res, 32'd0);
      tick();
      drive0(1'b1, T_ADD, 32'd10, 32'd20);
      drive1(1'b1, T_ADD, 32'd30, 32'd40);
      bus.i_rsp1_ready = 1'b1;
      tick();
      chk("rst_mid_pri", {bus.o_rsp1_valid, bus.o_rsp0_valid}, 2'b01);
      drive0(1'b0, T_ADD, 32'd0, 32'd0);
      drive1(1'b0, T_ADD, 32'd0, 32'd0);
      tick(); tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_err);
      $finish;
   end
endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH, operand and result width.
REQ-002 Parameter ARGS_WIDTH, default `ARGS_WIDTH, ALU operation code width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 i_clk  input  1  clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-007 o_reqN_ready  output  1  the block accepts requester N's operation this cycle.
REQ-008 i_reqN_type  input  ARGS_WIDTH  `ALU_TYPE_* code for requester N.
REQ-009 i_reqN_rs1_data, i_reqN_rs2_data  input  DATA_WIDTH  operands for requester N.
REQ-010 o_rspN_valid  output  1  result held for requester N.
REQ-011 i_rspN_ready  input  1  requester N consumes the result.
REQ-012 o_rsp_res  output  DATA_WIDTH  registered ALU result, shared by both response ports.
REQ-013 o_rsp_zero, o_rsp_over, o_rsp_neg  output  1 each  registered ALU flags.
REQ-014 o_busy  output  1  high while state is RESP.

Function
REQ-015 The block SHALL instantiate exactly one alu and share it between the two requesters.
REQ-016 States: IDLE (no result held) and RESP (result held for owner r_own).
REQ-017 Grant: only one requester valid -> that one; both valid -> the requester indicated by priority bit r_pri.
REQ-018 o_reqN_ready SHALL be high only for the granted requester, and only when state is IDLE or (RESP and i_rsp<r_own>_ready).
REQ-019 A request is accepted when valid and ready are both high; the ALU is driven by the granted requester's type and operands in that cycle.
REQ-020 On accept: the ALU result and flags are registered, r_own is set to the granted index, r_pri is set to the other index, and state goes to RESP.
REQ-021 Latency: o_rspN_valid rises the cycle after accept; exactly one response per accepted request.
REQ-022 In RESP, o_rsp<r_own>_valid = 1, the other response valid = 0, and the output registers SHALL remain stable until the response handshake.
REQ-023 In RESP, response handshake with no new accept -> IDLE; handshake with a same-cycle accept -> stay in RESP with the new result and owner (back-to-back, 1 op/cycle).
REQ-024 In RESP without i_rsp<r_own>_ready, both o_reqN_ready = 0 and no operands are sampled.
REQ-025 i_rsp of the non-owner SHALL be ignored.
REQ-026 r_pri SHALL change only on accept; a single active requester SHALL be granted regardless of r_pri.
REQ-027 Arithmetic, flag and width behaviour SHALL be exactly that of alu for the given type; undefined types return res 0, zero 1.
REQ-028 o_busy = (state == RESP).

Reset
REQ-029 With i_rst high at a clock edge: state = IDLE, r_pri = 0 (requester 0 favoured), r_own = 0, o_rsp_res = 0, all flags = 0, o_rspN_valid = 0, o_busy = 0.
REQ-030 Reset SHALL take priority over any same-cycle handshake; an in-flight result is discarded and no response is issued for it.
REQ-031 During reset, o_reqN_ready SHALL be 0.

Verification
REQ-032 Single op: req0 ADD 5,7 in IDLE -> accepted the same cycle; next cycle o_rsp0_valid = 1, res = 12, zero = 0; rsp0_ready -> IDLE.
REQ-033 Contention: after reset, req0 and req1 both valid (SUB 3,3 / XOR 0xF,0xF0) -> req0 granted first (res 0, zero 1), then req1 (res 0xFF); r_pri alternates on each accept.
REQ-034 Back-to-back: req1 holds 4 ADDs with i_rsp1_ready = 1 throughout -> 4 accepts in 4 consecutive cycles, 4 responses in order, busy continuously high.
REQ-035 Backpressure: result held with i_rsp0_ready = 0 for 5 cycles while req1 is valid -> o_req1_ready = 0, res/flags stable, then req1 is accepted in the cycle i_rsp0_ready = 1.
REQ-036 Overflow flag: ADD 0x8000..0, 0x8000..0 -> over = 1, res = 0, zero = 1.
REQ-037 Reset mid-operation: i_rst asserted in RESP -> next cycle o_rspN_valid = 0, o_busy = 0, r_pri = 0; the dropped result is never presented.
